// File: rtl/decoder_3to8_stream.sv
// Streaming registered binary-to-one-hot decoder with a 2-entry output buffer.
// Optional parity check on the input code is enabled by defining DECODER_PARITY_CHK_EN.
module decoder_3to8_stream #(
    parameter int IN_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      din,
    input  logic                 in_none,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2**IN_W-1:0]   dout,
    output logic [CNT_W-1:0]     dec_count,
    input  logic                 par_in,
    output logic                 par_err
);

    localparam int OUT_W = 2**IN_W;

    // Handshake: a word moves on a rising clk edge when valid && ready on that side.
    // in_ready and out_valid are registered and depend on buffer occupancy only.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic [OUT_W-1:0] head;
    logic [OUT_W-1:0] tail;
    logic [OUT_W-1:0] word;
    logic             accept;
    logic             keep;
    logic             xfer;
    logic             par_ok;

    always_comb begin
        word = '0;
        if (!in_none) begin
            word = OUT_W'(1) << din;
        end
    end

    assign accept = in_valid && in_ready;
    assign xfer   = out_valid && out_ready;

`ifdef DECODER_PARITY_CHK_EN
    // par_in must make {in_none, din, par_in} even parity.
    assign par_ok = ((^{in_none, din}) == par_in);
`else
    logic unused_par;
    assign unused_par = par_in;
    assign par_ok     = 1'b1;
`endif

    assign keep = accept && par_ok;

    // Head is cleared whenever the buffer empties so dout reads zero while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            head      <= '0;
            tail      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (keep) begin
                        head      <= word;
                        state     <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (keep && xfer) begin
                        head <= word;
                    end else if (keep) begin
                        tail     <= word;
                        state    <= TWO;
                        in_ready <= 1'b0;
                    end else if (xfer) begin
                        head      <= '0;
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        head     <= tail;
                        tail     <= '0;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    head      <= '0;
                    tail      <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dout = head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_count <= '0;
        end else if (xfer) begin
            dec_count <= dec_count + 1'b1;
        end
    end

`ifdef DECODER_PARITY_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= accept && !par_ok;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: doc/decoder_3to8_stream.md
Name: decoder_3to8_stream

Overview:
- Streaming registered binary-to-one-hot decoder: the inverse of the team's 8-to-3 encoder.
- Accepts a binary code (plus a "none" flag for the all-zero case) on a valid/ready interface.
- Presents the one-hot word on a valid/ready output through a 2-entry buffer, so back-pressure never drops codes.
- Sits downstream of encoder links to regenerate one-hot select lines.

Parameters:
- IN_W, 3, code width; output width is 2**IN_W (default 8).
- CNT_W, 16, width of the decoded-word counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  din/in_none valid
- in_ready  output  1  block can accept this cycle
- din  input  IN_W  binary code
- in_none  input  1  1 = no line active; output word all zeros, din ignored
- out_valid  output  1  dout valid
- out_ready  input  1  downstream accepts dout
- dout  output  2**IN_W  one-hot word (or zero)
- dec_count  output  CNT_W  number of words delivered downstream
- par_in  input  1  parity bit for din (used only with the optional feature)
- par_err  output  1  one-cycle error pulse (held 0 without the optional feature)

Behaviour:
- Reset (async, rst=1): buffer empty; out_valid=0, dout=0, in_ready=1, dec_count=0, par_err=0. Applies immediately, mid-transfer included; buffered words are discarded.
- Input accept on a clk edge when in_valid && in_ready.
- Output transfer on a clk edge when out_valid && out_ready.
- Decode rule:
  - in_none=1 -> word 0.
  - in_none=0 -> word has bit din set, all other bits 0.
  - Decode happens at accept time; the stored entry is the decoded word.
- Latency: a word accepted at edge N drives dout/out_valid after edge N when the buffer was empty. No combinational path from in_* to out_*.
- Buffer state machine, by occupancy:
  - EMPTY:
    - in_ready=1, out_valid=0.
    - accept -> ONE.
  - ONE:
    - in_ready=1, out_valid=1.
    - accept only -> TWO.
    - transfer only -> EMPTY.
    - accept and transfer in the same cycle -> ONE, with the new word at head.
  - TWO:
    - in_ready=0, out_valid=1.
    - transfer -> ONE; the second entry moves to head.
    - in_valid is ignored.
- in_ready is registered (function of state only), so there is no combinational path from out_ready to in_ready.
- dout holds its value while out_valid && !out_ready (AXI-style stability). dout is 0 when out_valid=0.
- Order is strictly FIFO.
- dec_count increments by 1 per output transfer and wraps from 2**CNT_W-1 to 0 without saturation.
- Simultaneous accept and transfer in ONE changes neither occupancy nor in_ready.

Optional Feature:
- Macro: DECODER_PARITY_CHK_EN.
- Defined:
  - At accept, the expected parity is the even parity over {in_none, din}; it must equal par_in.
  - On mismatch the word is dropped (not buffered, occupancy unchanged), and par_err pulses 1 for the cycle after the accept edge. The input handshake still completes (in_ready behaviour unchanged).
  - dec_count does not count dropped words.
- Undefined: par_in is ignored, par_err is tied to 0, and all words are buffered.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst mid-cycle with 2 words buffered.
  - Response: out_valid=0, dout=0, in_ready=1, dec_count=0 immediately, without waiting for a clk edge.
- Full sweep:
  - Stimulus: out_ready=1; din=0..7 back-to-back, then one word with in_none=1.
  - Response: dout sequence 00000001, 00000010, 00000100, 00001000, 00010000, 00100000, 01000000, 10000000, 00000000, each one cycle after accept; dec_count=9.
- Back-pressure:
  - Stimulus: out_ready=0; send din=3, 5, 6.
  - Response: 3 and 5 accepted; in_ready=0 in TWO, so 6 stalls. dout=00001000 stays stable.
  - Stimulus: then out_ready=1.
  - Response: outputs 00001000, 00100000, 01000000 in order.
- Simultaneous:
  - Stimulus: in ONE state holding din=2, present din=7 with out_ready=1.
  - Response: 00000100 transfers; the next cycle dout=10000000; occupancy stays ONE.
- Counter wrap:
  - Stimulus: CNT_W=4; 17 transfers.
  - Response: dec_count reads 1.
- Parity (with DECODER_PARITY_CHK_EN):
  - Stimulus: din=3, in_none=0, par_in=1 (wrong).
  - Response: par_err pulses 1 for one cycle, no output word, dec_count unchanged.
  - Stimulus: same din with par_in=0.
  - Response: decodes to 00001000.
